// File: rtl/load_store_controller.sv
// Load/store sequencer: aligns and issues one or two memory beats per request,
// extends load data, and reports completion, misalignment or per-beat timeout.
module load_store_controller #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic        i_rw,
  input  logic [1:0]  i_size,
  input  logic        i_sign_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_wdata_hi,
  output logic        o_busy,
  output logic        o_mem_mov,
  output logic        o_mem_rw,
  output logic [1:0]  o_mem_size,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_moc,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_rdata_hi,
  output logic        o_done,
  output logic        o_fault,
  output logic [1:0]  o_fault_code
);

  typedef enum logic [2:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP, S_FAULT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_next;
  logic        r_rw, r_sign;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, r_wdata_hi;
  logic [7:0]  r_cnt;
  logic [31:0] r_rdata, r_rdata_hi;
  logic        r_done, r_fault;
  logic [1:0]  r_fcode;

  logic        w_accept, w_misal, w_cap_lo, w_cap_hi, w_set_fc, w_in_beat, w_beat1;
  logic [1:0]  w_fc;

  function automatic logic [31:0] f_extend(input logic [31:0] raw, input logic [1:0] size,
                                           input logic sign);
    logic [31:0] v;
    v = raw;
    case (size)
      2'b00:   v[31:8]  = {24{sign & raw[7]}};
      2'b01:   v[31:16] = {16{sign & raw[15]}};
      default: v = raw;
    endcase
    return v;
  endfunction

  always_comb begin
    w_misal = 1'b0;
    case (i_size)
      2'b01:   w_misal = i_addr[0];
      2'b10:   w_misal = |i_addr[1:0];
      2'b11:   w_misal = |i_addr[2:0];
      default: w_misal = 1'b0;
    endcase
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_cap_lo = 1'b0;
    w_cap_hi = 1'b0;
    w_set_fc = 1'b0;
    w_fc     = r_fcode;
    case (r_state)
      S_IDLE: begin
        if (i_req) begin
          w_accept = 1'b1;
          if (w_misal) begin
            w_next   = S_FAULT;
            w_set_fc = 1'b1;
            w_fc     = 2'b01;
          end else begin
            w_next = S_BEAT0;
          end
        end
      end
      S_BEAT0, S_BEAT1: begin
        // A completion on the final counted cycle still wins over the timeout.
        if (i_mem_moc) begin
          w_cap_lo = r_rw && (r_state == S_BEAT0);
          w_cap_hi = r_rw && (r_state == S_BEAT1);
          w_next   = (r_state == S_BEAT0 && r_size == 2'b11) ? S_BEAT1 : S_RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_next   = S_FAULT;
          w_set_fc = 1'b1;
          w_fc     = 2'b10;
        end
      end
      S_RESP, S_FAULT: w_next = S_IDLE;
      default:         w_next = S_IDLE;
    endcase
  end

  assign w_in_beat = (r_state == S_BEAT0) || (r_state == S_BEAT1);
  assign w_beat1   = (r_state == S_BEAT1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rw       <= 1'b0;
      r_sign     <= 1'b0;
      r_size     <= 2'b00;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_wdata_hi <= 32'd0;
      r_cnt      <= 8'd0;
      r_rdata    <= 32'd0;
      r_rdata_hi <= 32'd0;
      r_done     <= 1'b0;
      r_fault    <= 1'b0;
      r_fcode    <= 2'b00;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_in_beat && w_next == r_state) ? r_cnt + 8'd1 : 8'd0;
      if (w_accept) begin
        r_rw       <= i_rw;
        r_sign     <= i_sign_en;
        r_size     <= i_size;
        r_addr     <= i_addr;
        r_wdata    <= i_wdata;
        r_wdata_hi <= i_wdata_hi;
      end
      if (w_cap_lo) r_rdata <= f_extend(i_mem_rdata, r_size, r_sign);
      if (w_cap_hi) r_rdata_hi <= i_mem_rdata;
      if (w_set_fc) r_fcode <= w_fc;
      r_done  <= (r_state == S_RESP);
      r_fault <= (r_state == S_FAULT);
    end
  end

  // Memory command is derived from the latched request; the second beat of a double
  // targets the next word and carries the high data word.
  assign o_busy       = (r_state != S_IDLE);
  assign o_mem_mov    = w_in_beat;
  assign o_mem_rw     = r_rw;
  assign o_mem_size   = (r_size == 2'b11) ? 2'b10 : r_size;
  assign o_mem_addr   = r_addr + {29'd0, w_beat1, 2'b00};
  assign o_mem_wdata  = w_beat1 ? r_wdata_hi : r_wdata;
  assign o_rdata      = r_rdata;
  assign o_rdata_hi   = r_rdata_hi;
  assign o_done       = r_done;
  assign o_fault      = r_fault;
  assign o_fault_code = r_fcode;

endmodule

// File: tb/tb_load_store_controller.sv
// Directed bench for load_store_controller: expected outcomes are queued when a
// request is driven and checked when the controller pulses done or fault.
module tb_load_store_controller;

  logic        clk, rst_n;
  logic        i_req, i_rw, i_sign_en, i_mem_moc;
  logic [1:0]  i_size;
  logic [31:0] i_addr, i_wdata, i_wdata_hi, i_mem_rdata;
  logic        o_busy, o_mem_mov, o_mem_rw, o_done, o_fault;
  logic [1:0]  o_mem_size, o_fault_code;
  logic [31:0] o_mem_addr, o_mem_wdata, o_rdata, o_rdata_hi;

  load_store_controller #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_rw(i_rw), .i_size(i_size),
    .i_sign_en(i_sign_en), .i_addr(i_addr), .i_wdata(i_wdata), .i_wdata_hi(i_wdata_hi),
    .o_busy(o_busy), .o_mem_mov(o_mem_mov), .o_mem_rw(o_mem_rw), .o_mem_size(o_mem_size),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_moc(i_mem_moc),
    .i_mem_rdata(i_mem_rdata), .o_rdata(o_rdata), .o_rdata_hi(o_rdata_hi),
    .o_done(o_done), .o_fault(o_fault), .o_fault_code(o_fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_fault;
    logic [1:0]  code;
    int          lat;
    logic [31:0] rd;
    logic [31:0] rdh;
    int          beats;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          nbeats;
  logic [31:0] log_addr[4];
  logic [31:0] log_wdata[4];
  logic [1:0]  log_size[4];
  logic        log_rw[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input bit f, input logic [1:0] c, input int l,
                              input logic [31:0] rd, input logic [31:0] rdh, input int b);
    exp_t e;
    e.is_fault = f; e.code = c; e.lat = l; e.rd = rd; e.rdh = rdh; e.beats = b;
    return e;
  endfunction

  // delay: wait cycles before mem_moc in each beat (-1 = never respond).
  task automatic do_access(input string tag, input logic rw, input logic [1:0] size,
                           input logic sign, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] wdh, input logic [31:0] rlo,
                           input logic [31:0] rhi, input int delay, input bit stray,
                           input exp_t e);
    exp_t got;
    bit   seen, both, new_beat;
    int   wait_c;
    @(negedge clk);
    i_req = 1'b1; i_rw = rw; i_size = size; i_sign_en = sign; i_addr = addr;
    i_wdata = wd; i_wdata_hi = wdh;
    sb.push_back(e);
    @(posedge clk);
    #1 i_req = 1'b0;
    nbeats = 0; new_beat = 1'b1; wait_c = 0; seen = 1'b0; both = 1'b0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk);
      if (o_done && o_fault) both = 1'b1;
      if (o_done || o_fault) begin
        seen = 1'b1;
        i_mem_moc = 1'b0;
        if (sb.size() == 0) begin
          chk({tag, "/unexpected"}, 32'd1, 32'd0);
        end else begin
          got = sb.pop_front();
          chk({tag, "/fault"},    {31'd0, o_fault}, {31'd0, got.is_fault});
          chk({tag, "/done"},     {31'd0, o_done},  {31'd0, !got.is_fault});
          chk({tag, "/code"},     {30'd0, o_fault_code}, {30'd0, got.code});
          chk({tag, "/latency"},  32'(n), 32'(got.lat));
          chk({tag, "/rdata"},    o_rdata, got.rd);
          chk({tag, "/rdata_hi"}, o_rdata_hi, got.rdh);
          chk({tag, "/beats"},    32'(nbeats), 32'(got.beats));
          chk({tag, "/both"},     {31'd0, both}, 32'd0);
        end
      end else begin
        if (stray) begin
          i_req = (n == 1);
          if (n == 1) i_addr = 32'hFFFF_FFFF;
        end
        if (o_mem_mov) begin
          if (new_beat) begin
            if (nbeats < 4) begin
              log_addr[nbeats] = o_mem_addr; log_wdata[nbeats] = o_mem_wdata;
              log_size[nbeats] = o_mem_size; log_rw[nbeats]    = o_mem_rw;
            end
            nbeats++; wait_c = 0; new_beat = 1'b0;
          end
          i_mem_moc   = (delay >= 0) && (wait_c == delay);
          i_mem_rdata = (nbeats == 1) ? rlo : rhi;
          if (i_mem_moc) new_beat = 1'b1;
          wait_c++;
        end else begin
          i_mem_moc = 1'b0;
        end
      end
    end
    i_req = 1'b0;
    i_mem_moc = 1'b0;
    if (!seen) chk({tag, "/complete"}, 32'd0, 32'd1);
    @(negedge clk);
    chk({tag, "/after"}, {28'd0, o_done, o_fault, o_busy, o_mem_mov}, 32'd0);
  endtask

  int ev;

  initial begin
    rst_n = 1'b0; i_req = 1'b0; i_rw = 1'b0; i_size = 2'b00; i_sign_en = 1'b0;
    i_addr = 32'd0; i_wdata = 32'd0; i_wdata_hi = 32'd0; i_mem_moc = 1'b0; i_mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset/ctrl", {28'd0, o_busy, o_mem_mov, o_done, o_fault}, 32'd0);
    chk("reset/addr", o_mem_addr, 32'd0);
    chk("reset/rdata", o_rdata, 32'd0);
    chk("reset/code", {30'd0, o_fault_code}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_access("sbyte", 1, 2'b00, 1, 32'h1003, 0, 0, 32'h0000_00F3, 0, 0, 0,
              mk(0, 2'b00, 3, 32'hFFFF_FFF3, 32'd0, 1));
    do_access("uhalf", 1, 2'b01, 0, 32'h2002, 0, 0, 32'h1234_8001, 0, 0, 1,
              mk(0, 2'b00, 3, 32'h0000_8001, 32'd0, 1));
    do_access("dstore", 0, 2'b11, 0, 32'h3000, 32'hA, 32'hB, 0, 0, 0, 0,
              mk(0, 2'b00, 4, 32'h0000_8001, 32'd0, 2));
    chk("dstore/addr0", log_addr[0], 32'h3000);
    chk("dstore/data0", log_wdata[0], 32'hA);
    chk("dstore/addr1", log_addr[1], 32'h3004);
    chk("dstore/data1", log_wdata[1], 32'hB);
    chk("dstore/size1", {30'd0, log_size[1]}, 32'd2);
    chk("dstore/rw0", {31'd0, log_rw[0]}, 32'd0);

    do_access("misword", 1, 2'b10, 0, 32'h4002, 0, 0, 0, 0, 0, 0,
              mk(1, 2'b01, 2, 32'h0000_8001, 32'd0, 0));
    do_access("timeout", 1, 2'b10, 0, 32'h4000, 0, 0, 32'hDEAD_BEEF, 0, -1, 0,
              mk(1, 2'b10, 6, 32'h0000_8001, 32'd0, 1));
    do_access("mocwins", 1, 2'b10, 0, 32'h4004, 0, 0, 32'hCAFE_F00D, 0, 3, 0,
              mk(0, 2'b10, 6, 32'hCAFE_F00D, 32'd0, 1));
    do_access("dload", 1, 2'b11, 1, 32'h6000, 0, 0, 32'h89AB_CDEF, 32'h0123_4567, 1, 0,
              mk(0, 2'b10, 6, 32'h89AB_CDEF, 32'h0123_4567, 2));
    chk("dload/addr1", log_addr[1], 32'h6004);
    chk("dload/size0", {30'd0, log_size[0]}, 32'd2);
    chk("dload/rw1", {31'd0, log_rw[1]}, 32'd1);

    do_access("sbyte_pos", 1, 2'b00, 1, 32'h7001, 0, 0, 32'hFFFF_FF73, 0, 0, 0,
              mk(0, 2'b10, 3, 32'h0000_0073, 32'h0123_4567, 1));
    do_access("shalf", 1, 2'b01, 1, 32'h7002, 0, 0, 32'h0000_8001, 0, 0, 0,
              mk(0, 2'b10, 3, 32'hFFFF_8001, 32'h0123_4567, 1));
    do_access("mishalf", 1, 2'b01, 0, 32'h7001, 0, 0, 0, 0, 0, 0,
              mk(1, 2'b01, 2, 32'hFFFF_8001, 32'h0123_4567, 0));
    do_access("misdbl", 0, 2'b11, 0, 32'h7004, 0, 0, 0, 0, 0, 0,
              mk(1, 2'b01, 2, 32'hFFFF_8001, 32'h0123_4567, 0));
    do_access("wstore", 0, 2'b10, 0, 32'h7008, 32'h5A5A_0001, 0, 32'h1111_2222, 0, 2, 1,
              mk(0, 2'b01, 5, 32'hFFFF_8001, 32'h0123_4567, 1));
    chk("wstore/data0", log_wdata[0], 32'h5A5A_0001);

    // Completion strobe outside an access must have no effect.
    i_mem_moc = 1'b1;
    @(negedge clk);
    i_mem_moc = 1'b0;
    chk("idle_moc", {29'd0, o_busy, o_done, o_fault}, 32'd0);

    // Abort a double load in its second beat.
    @(negedge clk);
    i_req = 1'b1; i_rw = 1'b1; i_size = 2'b11; i_sign_en = 1'b0; i_addr = 32'h5000;
    @(posedge clk);
    #1 i_req = 1'b0;
    @(negedge clk);
    chk("rst/beat0_mov", {31'd0, o_mem_mov}, 32'd1);
    i_mem_moc = 1'b1; i_mem_rdata = 32'h1111_1111;
    @(negedge clk);
    i_mem_moc = 1'b0;
    chk("rst/beat1_addr", o_mem_addr, 32'h5004);
    chk("rst/captured", o_rdata, 32'h1111_1111);
    #2 rst_n = 1'b0;
    #1;
    chk("rst/async_ctrl", {30'd0, o_mem_mov, o_busy}, 32'd0);
    chk("rst/async_addr", o_mem_addr, 32'd0);
    chk("rst/async_rdata", o_rdata, 32'd0);
    ev = 0;
    repeat (2) begin @(negedge clk); if (o_done || o_fault) ev++; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (o_done || o_fault) ev++; end
    chk("rst/no_pulse", 32'(ev), 32'd0);

    do_access("post_rst", 1, 2'b10, 0, 32'h8000, 0, 0, 32'h55AA_55AA, 0, 0, 0,
              mk(0, 2'b00, 3, 32'h55AA_55AA, 32'd0, 1));
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
